// File: rtl/test_io_ctrl.sv
// ---------------------------------------------------------------------------
// test_io_ctrl
//   Direction and turnaround controller that sits directly upstream of test_io.
//   Each command sets a new direction and drive value for every pin. A pin
//   that changes direction passes through a hi-Z turnaround window before the
//   new setting is applied. After the readback has settled, the controller
//   returns it on a valid/ready response together with a contention flag.
//   Rise and fall pulses are produced for pins in input mode.
//
//   oe polarity follows test_io:
//     oe=1 -> pin released (hi-Z, input)
//     oe=0 -> pin driven with drv
//
//   Optional build macro: TEST_IO_GLITCH_FILTER_EN
//     Adds a per-pin stability filter after the readback synchroniser.
//
// Ports
//   clk_i, rst_i            clock; synchronous active-high reset
//   cmd_valid_i/ready_o     command handshake
//   cmd_dir_i               1 = drive pin, 0 = input
//   cmd_data_i              drive value
//   rsp_valid_o/ready_i     response handshake
//   rsp_data_o              settled pin values
//   rsp_err_o               contention on an output-mode pin
//   port_oe_o, port_drv_o   to test_io (portN_oe, portN_i)
//   port_rd_i               from test_io (portN_o), asynchronous
//   rise_o, fall_o          1-cycle edge pulses, input-mode pins only
// ---------------------------------------------------------------------------
module test_io_ctrl #(
    parameter int NUM_PINS    = 2,
    parameter int TURN_CYC    = 2,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYC    = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic [NUM_PINS-1:0] cmd_dir_i,
    input  logic [NUM_PINS-1:0] cmd_data_i,
    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic [NUM_PINS-1:0] rsp_data_o,
    output logic                rsp_err_o,
    output logic [NUM_PINS-1:0] port_oe_o,
    output logic [NUM_PINS-1:0] port_drv_o,
    input  logic [NUM_PINS-1:0] port_rd_i,
    output logic [NUM_PINS-1:0] rise_o,
    output logic [NUM_PINS-1:0] fall_o
);

`ifdef TEST_IO_GLITCH_FILTER_EN
    localparam int SETTLE_CYC = SYNC_STAGES + FILT_CYC;
`else
    localparam int SETTLE_CYC = SYNC_STAGES;
`endif
    localparam int CNT_MAX = (SETTLE_CYC > TURN_CYC) ? SETTLE_CYC : TURN_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    // SETTLE holds SETTLE_CYC+1 cycles. The extra cycle covers the clock
    // it takes the pin to reflect the APPLY edge before the synchroniser
    // starts to see it.
    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC);
    localparam logic [CNT_W-1:0] TURN_LD   = CNT_W'((TURN_CYC > 0) ? TURN_CYC - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RELEASE,
        S_APPLY,
        S_SETTLE,
        S_RESP
    } state_e;

    state_e state_q, state_d;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [NUM_PINS-1:0] cmd_dir_q, cmd_dir_d;
    logic [NUM_PINS-1:0] cmd_data_q, cmd_data_d;
    logic [NUM_PINS-1:0] dir_q, dir_d;
    logic [NUM_PINS-1:0] port_oe_q, port_oe_d;
    logic [NUM_PINS-1:0] port_drv_q, port_drv_d;
    logic [NUM_PINS-1:0] prev_q, prev_d;
    logic [NUM_PINS-1:0] rise_q, rise_d;
    logic [NUM_PINS-1:0] fall_q, fall_d;
    logic [NUM_PINS-1:0] rsp_data_q, rsp_data_d;

    logic rsp_valid_q, rsp_valid_d;
    logic rsp_err_q, rsp_err_d;
    logic cmd_ready_q, cmd_ready_d;

    logic [SYNC_STAGES-1:0][NUM_PINS-1:0] sync_q, sync_d;
    logic [NUM_PINS-1:0] sync_val;
    logic [NUM_PINS-1:0] filt_val;
    logic                accept;

    assign sync_val = sync_q[SYNC_STAGES-1];

    // cmd_ready_q is registered and is high only while the FSM is in IDLE,
    // so there is no combinational path from valid to ready.
    assign accept = cmd_valid_i & cmd_ready_q;

    always_comb begin
        sync_d[0] = port_rd_i;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

`ifdef TEST_IO_GLITCH_FILTER_EN
    localparam int FCW = (FILT_CYC > 1) ? $clog2(FILT_CYC) : 1;
    localparam logic [FCW-1:0] FCNT_LAST = FCW'(FILT_CYC - 1);

    logic [NUM_PINS-1:0]          filt_q, filt_d;
    logic [NUM_PINS-1:0][FCW-1:0] fcnt_q, fcnt_d;

    // The filtered value follows the synchronised value only after that value
    // has differed from it for FILT_CYC consecutive cycles. The count restarts
    // whenever the two values agree again.
    always_comb begin
        for (int p = 0; p < NUM_PINS; p++) begin
            filt_d[p] = filt_q[p];
            fcnt_d[p] = '0;
            if (sync_val[p] != filt_q[p]) begin
                if (fcnt_q[p] == FCNT_LAST) begin
                    filt_d[p] = sync_val[p];
                end else begin
                    fcnt_d[p] = fcnt_q[p] + 1'b1;
                end
            end
        end
    end

    assign filt_val = filt_q;
`else
    assign filt_val = sync_val;
`endif

    // ---- state register ----
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            cmd_dir_q   <= '0;
            cmd_data_q  <= '0;
            dir_q       <= '0;
            port_oe_q   <= '1;
            port_drv_q  <= '0;
            sync_q      <= '0;
            prev_q      <= '0;
            rise_q      <= '0;
            fall_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            cmd_ready_q <= 1'b0;
`ifdef TEST_IO_GLITCH_FILTER_EN
            filt_q      <= '0;
            fcnt_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cmd_dir_q   <= cmd_dir_d;
            cmd_data_q  <= cmd_data_d;
            dir_q       <= dir_d;
            port_oe_q   <= port_oe_d;
            port_drv_q  <= port_drv_d;
            sync_q      <= sync_d;
            prev_q      <= prev_d;
            rise_q      <= rise_d;
            fall_q      <= fall_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            cmd_ready_q <= cmd_ready_d;
`ifdef TEST_IO_GLITCH_FILTER_EN
            filt_q      <= filt_d;
            fcnt_q      <= fcnt_d;
`endif
        end
    end

    // ---- next-state logic ----
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if ((cmd_dir_i != dir_q) && (TURN_CYC > 0)) begin
                        state_d = S_RELEASE;
                        cnt_d   = TURN_LD;
                    end else begin
                        state_d = S_APPLY;
                    end
                end
            end
            S_RELEASE: begin
                if (cnt_q == '0) begin
                    state_d = S_APPLY;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_APPLY: begin
                state_d = S_SETTLE;
                cnt_d   = SETTLE_LD;
            end
            S_SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_RESP: begin
                if (rsp_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ---- output / datapath logic ----
    always_comb begin
        cmd_ready_d = (state_d == S_IDLE);
        cmd_dir_d   = cmd_dir_q;
        cmd_data_d  = cmd_data_q;
        dir_d       = dir_q;
        port_oe_d   = port_oe_q;
        port_drv_d  = port_drv_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;

        if (state_q == S_IDLE && accept) begin
            cmd_dir_d  = cmd_dir_i;
            cmd_data_d = cmd_data_i;
            // Release only the pins that change direction. Pins that keep
            // their direction stay as they are, so they do not glitch.
            if (state_d == S_RELEASE) begin
                port_oe_d = port_oe_q | (cmd_dir_i ^ dir_q);
            end
        end

        if (state_q == S_APPLY) begin
            port_oe_d  = ~cmd_dir_q;
            port_drv_d = cmd_data_q & cmd_dir_q;
            dir_d      = cmd_dir_q;
        end

        if (state_q == S_SETTLE && state_d == S_RESP) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = filt_val;
            rsp_err_d   = |((filt_val ^ port_drv_q) & dir_q);
        end

        if (state_q == S_RESP && rsp_ready_i) begin
            rsp_valid_d = 1'b0;
        end

        // Edge detection runs continuously. When the direction is applied,
        // pulses are suppressed for one cycle so the reloaded previous value
        // does not produce a spurious edge.
        prev_d = filt_val;
        rise_d = filt_val & ~prev_q & ~dir_q;
        fall_d = ~filt_val & prev_q & ~dir_q;
        if (state_q == S_APPLY) begin
            rise_d = '0;
            fall_d = '0;
        end
    end

    assign cmd_ready_o = cmd_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign rsp_err_o   = rsp_err_q;
    assign port_oe_o   = port_oe_q;
    assign port_drv_o  = port_drv_q;
    assign rise_o      = rise_q;
    assign fall_o      = fall_q;

endmodule

// File: tb/tb_test_io_ctrl.sv
// Directed bench for test_io_ctrl in its default build (no glitch filter).
// The pin is modelled like test_io:
//   - released pins read the external value ext.
//   - driven pins read drv, unless the bench forces a contention value.
module tb_test_io_ctrl;
    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic       cmd_valid_i = 1'b0;
    logic       cmd_ready_o;
    logic [1:0] cmd_dir_i = 2'b00;
    logic [1:0] cmd_data_i = 2'b00;
    logic       rsp_valid_o;
    logic       rsp_ready_i = 1'b0;
    logic [1:0] rsp_data_o;
    logic       rsp_err_o;
    logic [1:0] port_oe_o;
    logic [1:0] port_drv_o;
    logic [1:0] port_rd_i;
    logic [1:0] rise_o;
    logic [1:0] fall_o;

    logic [1:0] ext = 2'b00;
    logic [1:0] force_en = 2'b00;
    logic [1:0] force_val = 2'b00;

    int errors = 0;
    int checks = 0;

    test_io_ctrl #(
        .NUM_PINS(2),
        .TURN_CYC(2),
        .SYNC_STAGES(2),
        .FILT_CYC(4)
    ) dut (
        .clk_i(clk),
        .rst_i(rst_i),
        .cmd_valid_i(cmd_valid_i),
        .cmd_ready_o(cmd_ready_o),
        .cmd_dir_i(cmd_dir_i),
        .cmd_data_i(cmd_data_i),
        .rsp_valid_o(rsp_valid_o),
        .rsp_ready_i(rsp_ready_i),
        .rsp_data_o(rsp_data_o),
        .rsp_err_o(rsp_err_o),
        .port_oe_o(port_oe_o),
        .port_drv_o(port_drv_o),
        .port_rd_i(port_rd_i),
        .rise_o(rise_o),
        .fall_o(fall_o)
    );

    assign port_rd_i = (port_oe_o & ext)
                     | (~port_oe_o & ((force_en & force_val) | (~force_en & port_drv_o)));

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        tick; tick;
        checks++; if (port_oe_o !== 2'b11) begin errors++; $display("FAIL reset_oe got=%b exp=11", port_oe_o); end
        checks++; if (port_drv_o !== 2'b00) begin errors++; $display("FAIL reset_drv got=%b exp=00", port_drv_o); end
        checks++; if (cmd_ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", cmd_ready_o); end
        checks++; if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid_o); end
        checks++; if ((rise_o | fall_o) !== 2'b00) begin errors++; $display("FAIL reset_edges got=%b/%b exp=00", rise_o, fall_o); end
        rst_i = 1'b0;
        checks++; if (cmd_ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready_same got=%b exp=0", cmd_ready_o); end
        tick;
        checks++; if (cmd_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready_after got=%b exp=1", cmd_ready_o); end
    endtask

    task automatic test_turnaround;
        cmd_dir_i = 2'b01; cmd_data_i = 2'b01; cmd_valid_i = 1'b1;
        tick;  // accept edge N
        cmd_valid_i = 1'b0;
        checks++; if (cmd_ready_o !== 1'b0) begin errors++; $display("FAIL turn_ready got=%b exp=0", cmd_ready_o); end
        checks++; if (port_oe_o !== 2'b11) begin errors++; $display("FAIL turn_oe_n0 got=%b exp=11", port_oe_o); end
        tick;  // N+1
        checks++; if (port_oe_o !== 2'b11) begin errors++; $display("FAIL turn_oe_n1 got=%b exp=11", port_oe_o); end
        tick;  // N+2
        checks++; if (port_oe_o !== 2'b11) begin errors++; $display("FAIL turn_oe_n2 got=%b exp=11", port_oe_o); end
        checks++; if (port_drv_o !== 2'b00) begin errors++; $display("FAIL turn_drv_n2 got=%b exp=00", port_drv_o); end
        tick;  // N+3
        checks++; if (port_oe_o !== 2'b10) begin errors++; $display("FAIL turn_oe_n3 got=%b exp=10", port_oe_o); end
        checks++; if (port_drv_o !== 2'b01) begin errors++; $display("FAIL turn_drv_n3 got=%b exp=01", port_drv_o); end
        tick; tick;  // N+5
        checks++; if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL turn_valid_n5 got=%b exp=0", rsp_valid_o); end
        tick;  // N+6
        checks++; if (rsp_valid_o !== 1'b1) begin errors++; $display("FAIL turn_valid_n6 got=%b exp=1", rsp_valid_o); end
        checks++; if (rsp_data_o !== 2'b01) begin errors++; $display("FAIL turn_data got=%b exp=01", rsp_data_o); end
        checks++; if (rsp_err_o !== 1'b0) begin errors++; $display("FAIL turn_err got=%b exp=0", rsp_err_o); end
        rsp_ready_i = 1'b1;
        tick;
        rsp_ready_i = 1'b0;
        checks++; if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL turn_valid_drop got=%b exp=0", rsp_valid_o); end
        checks++; if (cmd_ready_o !== 1'b1) begin errors++; $display("FAIL turn_ready_back got=%b exp=1", cmd_ready_o); end
    endtask

    task automatic test_same_dir;
        cmd_dir_i = 2'b01; cmd_data_i = 2'b00; cmd_valid_i = 1'b1;
        tick;  // N
        cmd_valid_i = 1'b0;
        checks++; if (port_oe_o !== 2'b10) begin errors++; $display("FAIL same_oe_n0 got=%b exp=10", port_oe_o); end
        checks++; if (port_drv_o !== 2'b01) begin errors++; $display("FAIL same_drv_n0 got=%b exp=01", port_drv_o); end
        tick;  // N+1
        checks++; if (port_drv_o !== 2'b00) begin errors++; $display("FAIL same_drv_n1 got=%b exp=00", port_drv_o); end
        checks++; if (port_oe_o !== 2'b10) begin errors++; $display("FAIL same_oe_n1 got=%b exp=10", port_oe_o); end
        tick; tick;  // N+3
        checks++; if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL same_valid_n3 got=%b exp=0", rsp_valid_o); end
        checks++; if (port_oe_o !== 2'b10) begin errors++; $display("FAIL same_oe_n3 got=%b exp=10", port_oe_o); end
        tick;  // N+4
        checks++; if (rsp_valid_o !== 1'b1) begin errors++; $display("FAIL same_valid_n4 got=%b exp=1", rsp_valid_o); end
        checks++; if (rsp_data_o !== 2'b00) begin errors++; $display("FAIL same_data got=%b exp=00", rsp_data_o); end
        rsp_ready_i = 1'b1;
        tick;
        rsp_ready_i = 1'b0;
    endtask

    task automatic test_contention;
        force_en = 2'b01; force_val = 2'b00;
        cmd_dir_i = 2'b01; cmd_data_i = 2'b01; cmd_valid_i = 1'b1;
        tick;
        cmd_valid_i = 1'b0;
        tick; tick; tick; tick;  // N+4
        checks++; if (port_drv_o !== 2'b01) begin errors++; $display("FAIL cont_drv got=%b exp=01", port_drv_o); end
        checks++; if (rsp_valid_o !== 1'b1) begin errors++; $display("FAIL cont_valid got=%b exp=1", rsp_valid_o); end
        checks++; if (rsp_err_o !== 1'b1) begin errors++; $display("FAIL cont_err got=%b exp=1", rsp_err_o); end
        checks++; if (rsp_data_o !== 2'b00) begin errors++; $display("FAIL cont_data got=%b exp=00", rsp_data_o); end
        rsp_ready_i = 1'b1;
        tick;
        rsp_ready_i = 1'b0;
    endtask

    task automatic test_edges;
        logic [1:0] exp_r;
        logic [1:0] exp_f;
        // Pin0 (output) now reads back high again; it must never pulse.
        force_en = 2'b00;
        for (int k = 1; k <= 4; k++) begin
            tick;
            checks++; if ((rise_o | fall_o) !== 2'b00) begin errors++; $display("FAIL edge_quiet%0d got=%b/%b exp=00", k, rise_o, fall_o); end
        end
        ext = 2'b10; force_en = 2'b01; force_val = 2'b00;
        for (int k = 1; k <= 4; k++) begin
            tick;
            exp_r = (k == 3) ? 2'b10 : 2'b00;
            checks++; if (rise_o !== exp_r) begin errors++; $display("FAIL edge_rise%0d got=%b exp=%b", k, rise_o, exp_r); end
            checks++; if (fall_o !== 2'b00) begin errors++; $display("FAIL edge_rise_nofall%0d got=%b exp=00", k, fall_o); end
        end
        ext = 2'b00; force_en = 2'b00;
        for (int k = 1; k <= 4; k++) begin
            tick;
            exp_f = (k == 3) ? 2'b10 : 2'b00;
            checks++; if (fall_o !== exp_f) begin errors++; $display("FAIL edge_fall%0d got=%b exp=%b", k, fall_o, exp_f); end
            checks++; if (rise_o !== 2'b00) begin errors++; $display("FAIL edge_fall_norise%0d got=%b exp=00", k, rise_o); end
        end
    endtask

    task automatic test_hold_reset;
        cmd_dir_i = 2'b01; cmd_data_i = 2'b00; cmd_valid_i = 1'b1;
        tick;
        cmd_valid_i = 1'b0;
        tick; tick; tick; tick;  // N+4
        checks++; if (rsp_valid_o !== 1'b1) begin errors++; $display("FAIL hold_valid0 got=%b exp=1", rsp_valid_o); end
        ext = 2'b10;  // pin1 changes while the response is held
        for (int k = 1; k <= 5; k++) begin
            tick;
            checks++; if (rsp_valid_o !== 1'b1) begin errors++; $display("FAIL hold_valid%0d got=%b exp=1", k, rsp_valid_o); end
            checks++; if (rsp_data_o !== 2'b00) begin errors++; $display("FAIL hold_data%0d got=%b exp=00", k, rsp_data_o); end
            checks++; if (cmd_ready_o !== 1'b0) begin errors++; $display("FAIL hold_ready%0d got=%b exp=0", k, cmd_ready_o); end
        end
        rsp_ready_i = 1'b1;
        tick;
        rsp_ready_i = 1'b0;
        checks++; if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL hold_drop got=%b exp=0", rsp_valid_o); end
        // Reset while in RELEASE: only pin1 changes direction.
        cmd_dir_i = 2'b11; cmd_data_i = 2'b10; cmd_valid_i = 1'b1;
        tick;
        cmd_valid_i = 1'b0;
        checks++; if (port_oe_o !== 2'b10) begin errors++; $display("FAIL rel_oe got=%b exp=10", port_oe_o); end
        rst_i = 1'b1;
        tick;
        checks++; if (port_oe_o !== 2'b11) begin errors++; $display("FAIL rst_oe got=%b exp=11", port_oe_o); end
        checks++; if (port_drv_o !== 2'b00) begin errors++; $display("FAIL rst_drv got=%b exp=00", port_drv_o); end
        checks++; if (cmd_ready_o !== 1'b0) begin errors++; $display("FAIL rst_ready got=%b exp=0", cmd_ready_o); end
        rst_i = 1'b0;
        tick;
        checks++; if (cmd_ready_o !== 1'b1) begin errors++; $display("FAIL rst_idle_ready got=%b exp=1", cmd_ready_o); end
        for (int k = 0; k < 8; k++) tick;
        checks++; if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL rst_no_rsp got=%b exp=0", rsp_valid_o); end
        checks++; if (port_oe_o !== 2'b11) begin errors++; $display("FAIL rst_oe_late got=%b exp=11", port_oe_o); end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

    initial begin
        test_reset;
        test_turnaround;
        test_same_dir;
        test_contention;
        test_edges;
        test_hold_reset;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
